// File: rtl/id_pkg.sv
// Shared types and constants for the instruction-decode issue queue.
package id_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/id_scoreboard.sv
// Load-use scoreboard: one 3-bit down-counter per GPR, two busy read ports.
module id_scoreboard
  import id_pkg::*;
#(
  parameter int LOAD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic [REG_ADDR_W-1:0] rd_a_addr,
  input  logic [REG_ADDR_W-1:0] rd_b_addr,
  output logic                  busy_a,
  output logic                  busy_b
);

  localparam logic [2:0] LAT = 3'(LOAD_LAT);

  logic [2:0]          cnt [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec;

  // A load issuing to a register overrides that register's decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (set_en && set_addr == REG_ADDR_W'(i)) cnt[i] <= LAT;
        else if (cnt[i] != 3'd0)                   cnt[i] <= cnt[i] - 3'd1;
      end
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) busy_vec[i] = (cnt[i] != 3'd0);
  end

  assign busy_a = busy_vec[rd_a_addr];
  assign busy_b = busy_vec[rd_b_addr];

endmodule

// File: rtl/id_issue_queue.sv
// Decode-stage issue queue with load-use interlock.
// Optional zero-latency empty-queue bypass: define ID_ISSUE_BYPASS_EN.
module id_issue_queue
  import id_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LOAD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_pc,
  input  logic [31:0]             in_inst,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_pc,
  output logic [31:0]             out_inst,
  input  logic                    src_rs_used,
  input  logic                    src_rt_used,
  input  logic                    dst_is_load,
  input  logic [REG_ADDR_W-1:0]   dst_addr,
  input  logic                    flush,
  output logic                    stallreq,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  iq_entry_t              mem [DEPTH];
  iq_entry_t              head;
  iq_entry_t              last_q;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [OCC_W-1:0]       occ;
  logic [REG_ADDR_W-1:0]  rs;
  logic [REG_ADDR_W-1:0]  rt;
  logic empty, full, bypass, hazard, busy_rs, busy_rt;
  logic pop, q_pop, push, load_issue;

  assign empty = (occ == '0);
  assign full  = (occ == OCC_W'(DEPTH));

`ifdef ID_ISSUE_BYPASS_EN
  // Selection ignores the hazard so the external decoder never closes a loop;
  // a hazarded bypass simply shows out_valid=0 and gets enqueued.
  assign bypass = empty & in_valid & ~flush & ~rst;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    head = last_q;
    if (bypass) begin
      head.pc   = in_pc;
      head.inst = in_inst;
    end else if (!empty) begin
      head = mem[rd_ptr];
    end
  end

  assign rs = head.inst[RS_HI:RS_LO];
  assign rt = head.inst[RT_HI:RT_LO];

  assign hazard = (src_rs_used & (rs != '0) & busy_rs) |
                  (src_rt_used & (rt != '0) & busy_rt);

  assign out_valid = ~rst & (~empty | bypass) & ~hazard & ~flush;
  assign stallreq  = ~rst & ~empty & hazard;
  assign in_ready  = ~rst & ~full & ~flush;

  assign pop        = out_valid & out_ready;
  assign q_pop      = pop & ~bypass;
  assign push       = in_valid & in_ready & ~(bypass & pop);
  assign load_issue = pop & dst_is_load & (dst_addr != '0);

  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign occupancy = occ;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr].pc   <= in_pc;
      mem[wr_ptr].inst <= in_inst;
    end
  end

  // last_q tracks what is presented so an empty queue holds the last head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      last_q <= '0;
    end else begin
      last_q <= head;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
        if (q_pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !q_pop)      occ <= occ + OCC_W'(1);
        else if (q_pop && !push) occ <= occ - OCC_W'(1);
      end
    end
  end

  id_scoreboard #(
    .LOAD_LAT (LOAD_LAT)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (load_issue),
    .set_addr  (dst_addr),
    .rd_a_addr (rs),
    .rd_b_addr (rt),
    .busy_a    (busy_rs),
    .busy_b    (busy_rt)
  );

endmodule

// File: tb/tb_id_issue_queue.sv
// Directed self-checking bench for id_issue_queue (LOAD_LAT=2 and LOAD_LAT=4 instances).
module tb_id_issue_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] LW_R5  = 32'h8C25_0000;
  localparam logic [31:0] ADDU6  = 32'h00A7_3021;
  localparam logic [31:0] LW_R0  = 32'h8C20_0000;
  localparam logic [31:0] ADDU_0 = 32'h0000_4021;
  localparam logic [31:0] LW_R9  = 32'h8C29_0000;
  localparam logic [31:0] USE_R9 = 32'h0120_5021;

  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic        src_rs_used, src_rt_used, dst_is_load, flush, stallreq;
  logic [4:0]  dst_addr;
  logic [2:0]  occupancy;

  logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_pc, b_in_inst, b_out_pc, b_out_inst;
  logic        b_src_rs_used, b_src_rt_used, b_dst_is_load, b_flush, b_stallreq;
  logic [4:0]  b_dst_addr;
  logic [2:0]  b_occupancy;

  id_issue_queue #(.DEPTH(4), .LOAD_LAT(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .src_rs_used(src_rs_used),
    .src_rt_used(src_rt_used), .dst_is_load(dst_is_load), .dst_addr(dst_addr),
    .flush(flush), .stallreq(stallreq), .occupancy(occupancy)
  );

  id_issue_queue #(.DEPTH(4), .LOAD_LAT(4)) u_dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_pc(b_in_pc), .in_inst(b_in_inst), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc(b_out_pc), .out_inst(b_out_inst), .src_rs_used(b_src_rs_used),
    .src_rt_used(b_src_rt_used), .dst_is_load(b_dst_is_load), .dst_addr(b_dst_addr),
    .flush(b_flush), .stallreq(b_stallreq), .occupancy(b_occupancy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic dec(input logic rs_u, input logic rt_u, input logic ld, input logic [4:0] d);
    src_rs_used = rs_u; src_rt_used = rt_u; dst_is_load = ld; dst_addr = d;
  endtask

  task automatic b_dec(input logic rs_u, input logic rt_u, input logic ld, input logic [4:0] d);
    b_src_rs_used = rs_u; b_src_rt_used = rt_u; b_dst_is_load = ld; b_dst_addr = d;
  endtask

  task automatic push_a(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1; in_pc = pc; in_inst = inst;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push_b(input logic [31:0] pc, input logic [31:0] inst);
    b_in_valid = 1'b1; b_in_pc = pc; b_in_inst = inst;
    tick();
    b_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_pc = 32'hDEAD_0000; in_inst = '0;
    out_ready = 1'b1; flush = 1'b0; dec(1'b0, 1'b0, 1'b0, 5'd0);
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_pc = '0; b_in_inst = '0;
    b_out_ready = 1'b0; b_flush = 1'b0; b_dec(1'b0, 1'b0, 1'b0, 5'd0);

    // ---------------- reset ----------------
    tick(); tick(); settle();
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_b("rst_stallreq",  stallreq,  1'b0);
    chk_b("rst_in_ready",  in_ready,  1'b0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; settle();
    chk_w("post_rst_occ",     32'(occupancy), 32'd0);
    chk_w("post_rst_out_pc",  out_pc,   32'h0);
    chk_w("post_rst_out_inst", out_inst, 32'h0);
    chk_b("post_rst_in_ready", in_ready, 1'b1);
    chk_b("post_rst_out_valid", out_valid, 1'b0);

    // ---------------- fill: 5 pushes into DEPTH=4 ----------------
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_pc = 32'h100 + 32'(4 * k); in_inst = 32'(k);
      settle();
      chk_b("fill_in_ready", in_ready, (k < 4));
      if (k == 1) chk_b("fill_latency_out_valid", out_valid, 1'b1);
      tick();
    end
    in_valid = 1'b0; settle();
    chk_w("fill_occ", 32'(occupancy), 32'd4);
    chk_w("fill_head_pc", out_pc, 32'h100);

    // ---------------- full: push + pop same cycle ----------------
    in_valid = 1'b1; in_pc = 32'h200; in_inst = 32'h77; out_ready = 1'b1; settle();
    chk_b("full_in_ready", in_ready, 1'b0);
    chk_b("full_out_valid", out_valid, 1'b1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0; settle();
    chk_w("full_pop_occ", 32'(occupancy), 32'd3);

    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      settle();
      chk_w("drain_pc", out_pc, 32'h100 + 32'(4 * k));
      tick();
    end
    out_ready = 1'b0; settle();
    chk_w("drain_occ", 32'(occupancy), 32'd0);
    chk_b("drain_out_valid", out_valid, 1'b0);
    chk_w("empty_hold_pc", out_pc, 32'h10C);

    // ---------------- load-use: lw r5; addu r6,r5,r7 ----------------
    push_a(32'h10, LW_R5);
    push_a(32'h14, ADDU6);
    dec(1'b1, 1'b0, 1'b1, 5'd5); out_ready = 1'b1; settle();
    chk_b("lu_lw_valid", out_valid, 1'b1);
    chk_w("lu_lw_inst", out_inst, LW_R5);
    tick();
    dec(1'b1, 1'b1, 1'b0, 5'd6); settle();
    chk_b("lu_stall_t1", stallreq, 1'b1);
    chk_b("lu_valid_t1", out_valid, 1'b0);
    tick(); settle();
    chk_b("lu_stall_t2", stallreq, 1'b1);
    tick(); settle();
    chk_b("lu_stall_t3", stallreq, 1'b0);
    chk_b("lu_valid_t3", out_valid, 1'b1);
    chk_w("lu_inst_t3", out_inst, ADDU6);
    tick();
    out_ready = 1'b0; dec(1'b0, 1'b0, 1'b0, 5'd0); settle();
    chk_w("lu_occ", 32'(occupancy), 32'd0);

    // ---------------- back-to-back loads to r5 ----------------
    push_a(32'h20, LW_R5);
    push_a(32'h24, LW_R5);
    push_a(32'h28, ADDU6);
    dec(1'b1, 1'b0, 1'b1, 5'd5); out_ready = 1'b1; settle();
    chk_w("b2b_first_pc", out_pc, 32'h20);
    tick(); settle();
    chk_b("b2b_second_valid", out_valid, 1'b1);
    chk_w("b2b_second_pc", out_pc, 32'h24);
    tick();
    dec(1'b1, 1'b1, 1'b0, 5'd6); settle();
    chk_b("b2b_stall_1", stallreq, 1'b1);
    tick(); settle();
    chk_b("b2b_stall_2", stallreq, 1'b1);
    tick(); settle();
    chk_b("b2b_stall_3", stallreq, 1'b0);
    chk_w("b2b_issue_pc", out_pc, 32'h28);
    tick();
    out_ready = 1'b0; dec(1'b0, 1'b0, 1'b0, 5'd0);

    // ---------------- load to r0 then consumer of r0 ----------------
    push_a(32'h30, LW_R0);
    push_a(32'h34, ADDU_0);
    dec(1'b1, 1'b0, 1'b1, 5'd0); out_ready = 1'b1; settle();
    chk_b("r0_lw_valid", out_valid, 1'b1);
    tick();
    dec(1'b1, 1'b1, 1'b0, 5'd8); settle();
    chk_b("r0_no_stall", stallreq, 1'b0);
    chk_b("r0_use_valid", out_valid, 1'b1);
    tick();
    out_ready = 1'b0; dec(1'b0, 1'b0, 1'b0, 5'd0); settle();
    chk_w("r0_occ", 32'(occupancy), 32'd0);

`ifdef ID_ISSUE_BYPASS_EN
    // ---------------- zero-latency bypass ----------------
    in_valid = 1'b1; in_pc = 32'h1000; in_inst = 32'h0; out_ready = 1'b1; settle();
    chk_b("byp_out_valid", out_valid, 1'b1);
    chk_w("byp_out_pc", out_pc, 32'h1000);
    tick();
    in_valid = 1'b0; out_ready = 1'b0; settle();
    chk_w("byp_occ", 32'(occupancy), 32'd0);
`endif

    // ---------------- flush with scoreboard in flight (LOAD_LAT=4) ----------------
    b_rst = 1'b0;
    push_b(32'h300, LW_R9);
    push_b(32'h304, 32'h0);
    push_b(32'h308, 32'h0);
    push_b(32'h30C, 32'h0);
    b_dec(1'b1, 1'b0, 1'b1, 5'd9); b_out_ready = 1'b1; settle();
    chk_b("fl_lw_valid", b_out_valid, 1'b1);
    tick(); settle();
    chk_w("fl_pre_occ", 32'(b_occupancy), 32'd3);
    b_flush = 1'b1; b_in_valid = 1'b1; b_in_pc = 32'h400; b_in_inst = 32'h0;
    b_dec(1'b0, 1'b0, 1'b0, 5'd0); settle();
    chk_b("fl_in_ready", b_in_ready, 1'b0);
    chk_b("fl_out_valid", b_out_valid, 1'b0);
    tick();
    b_flush = 1'b0; b_in_valid = 1'b0; settle();
    chk_w("fl_occ", 32'(b_occupancy), 32'd0);
    b_out_ready = 1'b0;
    push_b(32'h500, USE_R9);
    b_dec(1'b1, 1'b1, 1'b0, 5'd10); settle();
    chk_w("fl_dropped_occ", 32'(b_occupancy), 32'd1);
    chk_w("fl_head_pc", b_out_pc, 32'h500);
    chk_b("fl_sb_kept_stall", b_stallreq, 1'b1);
    b_out_ready = 1'b1;
    tick(); settle();
    chk_b("fl_sb_stall_2", b_stallreq, 1'b1);
    tick(); settle();
    chk_b("fl_sb_release", b_stallreq, 1'b0);
    chk_b("fl_sb_issue", b_out_valid, 1'b1);
    tick();
    b_out_ready = 1'b0; b_dec(1'b0, 1'b0, 1'b0, 5'd0); settle();
    chk_w("fl_end_occ", 32'(b_occupancy), 32'd0);

    // ---------------- reset mid-operation ----------------
    push_b(32'h600, LW_R9);
    push_b(32'h604, USE_R9);
    b_dec(1'b1, 1'b0, 1'b1, 5'd9); b_out_ready = 1'b1; settle();
    tick();
    b_rst = 1'b1; b_dec(1'b1, 1'b1, 1'b0, 5'd10); settle();
    chk_b("rm_no_issue", b_out_valid, 1'b0);
    chk_b("rm_no_stallreq", b_stallreq, 1'b0);
    tick();
    b_rst = 1'b0; b_out_ready = 1'b0; settle();
    chk_w("rm_occ", 32'(b_occupancy), 32'd0);
    chk_b("rm_out_valid", b_out_valid, 1'b0);
    chk_w("rm_out_pc", b_out_pc, 32'h0);
    push_b(32'h700, USE_R9);
    settle();
    chk_b("rm_sb_cleared", b_stallreq, 1'b0);
    chk_b("rm_use_valid", b_out_valid, 1'b1);
    b_out_ready = 1'b1;
    tick(); settle();
    chk_w("rm_end_occ", 32'(b_occupancy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
